// File: rtl/mprj_status_monitor.sv
// mprj_status_monitor: synchronises and debounces the firmware status word,
// decodes per-test start/pass/fail codes, runs one small FSM per sub-test and
// raises sticky done / fail / timeout flags plus a watchdog.
// Optional feature macro: MON_STRICT_ORDER_EN (tests must start in ascending order).
module mprj_status_monitor #(
  parameter int unsigned             WIDTH          = 16,
  parameter int unsigned             NUM_TESTS      = 4,
  parameter logic [NUM_TESTS*8-1:0]  TAGS           = {8'h50, 8'h10, 8'h20, 8'h40},
  parameter logic [WIDTH-9:0]        START_HI       = (WIDTH-8)'('hA0),
  parameter logic [WIDTH-9:0]        RESULT_HI      = (WIDTH-8)'('hAB),
  parameter int unsigned             STABLE_CYCLES  = 4,
  parameter int unsigned             TIMEOUT_CYCLES = 500000
) (
  input  logic                 clock,
  input  logic                 resetb,
  input  logic [WIDTH-1:0]     status,
  output logic                 event_valid,
  output logic [3:0]           event_test,
  output logic [1:0]           event_kind,
  output logic [NUM_TESTS-1:0] pass_mask,
  output logic [NUM_TESTS-1:0] fail_mask,
  output logic                 done,
  output logic                 fail,
  output logic                 timeout
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUNNING, ST_PASSED, ST_FAILED} test_state_e;

  localparam logic [1:0]  KIND_START = 2'd0;
  localparam logic [1:0]  KIND_PASS  = 2'd1;
  localparam logic [1:0]  KIND_FAIL  = 2'd2;
  localparam logic [1:0]  KIND_PERR  = 2'd3;
  localparam logic [7:0]  STABLE_MAX = 8'(STABLE_CYCLES);
  localparam logic [31:0] WD_LIMIT   = 32'(TIMEOUT_CYCLES);

  // Stability counter saturates at the acceptance threshold.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v >= STABLE_MAX) ? STABLE_MAX : v + 8'd1;
  endfunction

  logic [WIDTH-1:0]     s1_q, s2_q;
  logic [7:0]           stable_cnt_q, stable_cnt_d;
  logic                 seen_q, seen_d;
  logic                 accept, hit, is_start, is_pass, is_fail;
  logic                 recognised, frozen, code_ok, wd_clear, order_err;
  logic [3:0]           hit_idx;
  test_state_e          state_q [NUM_TESTS];
  test_state_e          state_d [NUM_TESTS];
  logic [NUM_TESTS-1:0] pass_d, fail_mask_q, fail_mask_d;
  logic                 ev_valid_q, ev_valid_d;
  logic [3:0]           ev_test_q, ev_test_d;
  logic [1:0]           ev_kind_q, ev_kind_d;
  logic [31:0]          wd_q, wd_d;
  logic                 timeout_q, timeout_d, fail_q, fail_d, done_q, done_d;

  // Debounce: restart counting whenever s2 is about to change; each stable value fires once.
  always_comb begin
    accept = (stable_cnt_q == STABLE_MAX) && !seen_q;
    if (s1_q != s2_q) begin
      stable_cnt_d = 8'd1;
      seen_d       = 1'b0;
    end else begin
      stable_cnt_d = sat_inc(stable_cnt_q);
      seen_d       = seen_q | accept;
    end
  end

  // Decode the stable word: lowest-index tag match wins, bit 0 separates pass from fail.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 4'd0;
    for (int i = 0; i < NUM_TESTS; i++) begin
      if (!hit && (s2_q[7:1] == TAGS[8*i+1 +: 7])) begin
        hit     = 1'b1;
        hit_idx = 4'(i);
      end
    end
    is_start   = (s2_q[WIDTH-1:8] == START_HI)  && !s2_q[0];
    is_pass    = (s2_q[WIDTH-1:8] == RESULT_HI) &&  s2_q[0];
    is_fail    = (s2_q[WIDTH-1:8] == RESULT_HI) && !s2_q[0];
    recognised = hit && (is_start || is_pass || is_fail);
    frozen     = done_q || fail_q;
    code_ok    = accept && recognised && !frozen;
  end

  // Per-test FSM next state, event generation, sticky flags and watchdog.
  always_comb begin
    state_d     = state_q;
    fail_mask_d = fail_mask_q;
    fail_d      = fail_q;
    timeout_d   = timeout_q;
    wd_d        = wd_q;
    ev_valid_d  = 1'b0;
    ev_test_d   = 4'd0;
    ev_kind_d   = KIND_START;
    wd_clear    = code_ok;
    order_err   = 1'b0;
    for (int i = 0; i < NUM_TESTS; i++) begin
      order_err = 1'b0;
`ifdef MON_STRICT_ORDER_EN
      for (int j = 0; j < i; j++) begin
        if (state_q[j] == ST_IDLE || state_q[j] == ST_RUNNING) order_err = 1'b1;
      end
`endif
      if (code_ok && (hit_idx == 4'(i))) begin
        ev_test_d = 4'(i);
        case (state_q[i])
          ST_IDLE: begin
            ev_valid_d = 1'b1;
            if (is_start && !order_err) begin
              state_d[i] = ST_RUNNING;
              ev_kind_d  = KIND_START;
            end else begin
              state_d[i] = ST_FAILED;
              ev_kind_d  = KIND_PERR;
            end
          end
          ST_RUNNING: begin
            // A repeated start only refreshes the watchdog.
            if (is_pass) begin
              state_d[i] = ST_PASSED;
              ev_valid_d = 1'b1;
              ev_kind_d  = KIND_PASS;
            end else if (is_fail) begin
              state_d[i] = ST_FAILED;
              ev_valid_d = 1'b1;
              ev_kind_d  = KIND_FAIL;
            end
          end
          default: begin
            ev_valid_d = 1'b1;
            ev_kind_d  = KIND_PERR;
          end
        endcase
        if (ev_valid_d && (ev_kind_d == KIND_FAIL || ev_kind_d == KIND_PERR)) begin
          fail_mask_d[i] = 1'b1;
          fail_d         = 1'b1;
        end
      end
    end
    // A code accepted in the expiry cycle clears the counter and wins over the timeout.
    if (!frozen) begin
      if (wd_clear) begin
        wd_d = 32'd0;
      end else begin
        wd_d = wd_q + 32'd1;
        if ((WD_LIMIT != 32'd0) && (wd_d >= WD_LIMIT)) begin
          timeout_d = 1'b1;
          fail_d    = 1'b1;
        end
      end
    end
    for (int i = 0; i < NUM_TESTS; i++) pass_d[i] = (state_d[i] == ST_PASSED);
    done_d = done_q || ((&pass_d) && !fail_d);
  end

  // All state, including the synchroniser, clears asynchronously on resetb.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      s1_q         <= '0;
      s2_q         <= '0;
      stable_cnt_q <= 8'd0;
      seen_q       <= 1'b0;
      for (int i = 0; i < NUM_TESTS; i++) state_q[i] <= ST_IDLE;
      fail_mask_q  <= '0;
      ev_valid_q   <= 1'b0;
      ev_test_q    <= 4'd0;
      ev_kind_q    <= 2'd0;
      wd_q         <= 32'd0;
      timeout_q    <= 1'b0;
      fail_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      s1_q         <= status;
      s2_q         <= s1_q;
      stable_cnt_q <= stable_cnt_d;
      seen_q       <= seen_d;
      state_q      <= state_d;
      fail_mask_q  <= fail_mask_d;
      ev_valid_q   <= ev_valid_d;
      ev_test_q    <= ev_test_d;
      ev_kind_q    <= ev_kind_d;
      wd_q         <= wd_d;
      timeout_q    <= timeout_d;
      fail_q       <= fail_d;
      done_q       <= done_d;
    end
  end

  // Pass mask reflects the registered FSM states.
  always_comb begin
    for (int i = 0; i < NUM_TESTS; i++) pass_mask[i] = (state_q[i] == ST_PASSED);
  end

  assign event_valid = ev_valid_q;
  assign event_test  = ev_test_q;
  assign event_kind  = ev_kind_q;
  assign fail_mask   = fail_mask_q;
  assign done        = done_q;
  assign fail        = fail_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_mprj_status_monitor.sv
// Directed self-checking bench for mprj_status_monitor (default tags, STABLE_CYCLES=4,
// TIMEOUT_CYCLES=100).
module tb_mprj_status_monitor;

  logic        clock = 1'b0;
  logic        resetb = 1'b0;
  logic [15:0] status = 16'h0000;
  logic        event_valid;
  logic [3:0]  event_test;
  logic [1:0]  event_kind;
  logic [3:0]  pass_mask, fail_mask;
  logic        done, fail, timeout;

  int checks = 0;
  int passed = 0;
  logic [3:0] evt_q[$];
  logic [1:0] evk_q[$];

  mprj_status_monitor #(
    .WIDTH(16), .NUM_TESTS(4), .STABLE_CYCLES(4), .TIMEOUT_CYCLES(100)
  ) dut (
    .clock(clock), .resetb(resetb), .status(status),
    .event_valid(event_valid), .event_test(event_test), .event_kind(event_kind),
    .pass_mask(pass_mask), .fail_mask(fail_mask),
    .done(done), .fail(fail), .timeout(timeout)
  );

  always #5 clock = ~clock;

  // Record every accepted event, sampled just after the rising edge.
  always @(posedge clock) begin
    #1;
    if (event_valid) begin
      evt_q.push_back(event_test);
      evk_q.push_back(event_kind);
    end
  end

  task automatic apply_reset();
    @(negedge clock);
    resetb = 1'b0;
    status = 16'h0000;
    repeat (3) @(negedge clock);
    resetb = 1'b1;
    evt_q.delete();
    evk_q.delete();
  endtask

  task automatic hold(input logic [15:0] code, input int n);
    status = code;
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({event_valid, pass_mask, fail_mask, done, fail, timeout} !== 12'h000)
      $display("FAIL reset_outputs: got %h want 000",
               {event_valid, pass_mask, fail_mask, done, fail, timeout});
    else passed++;
  endtask

  task automatic test_all_pass();
    logic [15:0] seq [8] = '{16'hA040, 16'hAB41, 16'hA020, 16'hAB21,
                             16'hA010, 16'hAB11, 16'hA050, 16'hAB51};
    apply_reset();
    for (int i = 0; i < 8; i++) hold(seq[i], 10);
    checks++;
    if (evt_q.size() != 8) $display("FAIL pass_event_count: got %0d want 8", evt_q.size());
    else passed++;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= evt_q.size())
        $display("FAIL pass_event_%0d: missing, want test %0d kind %0d", i, i / 2, i % 2);
      else if (evt_q[i] !== 4'(i / 2) || evk_q[i] !== 2'(i % 2))
        $display("FAIL pass_event_%0d: got test %0d kind %0d want test %0d kind %0d",
                 i, evt_q[i], evk_q[i], i / 2, i % 2);
      else passed++;
    end
    checks++;
    if (pass_mask !== 4'hF) $display("FAIL pass_mask_all: got %h want f", pass_mask);
    else passed++;
    checks++;
    if ({done, fail, fail_mask} !== 6'b10_0000)
      $display("FAIL done_flag: got done=%b fail=%b fail_mask=%h want 1 0 0", done, fail, fail_mask);
    else passed++;
  endtask

  task automatic test_fail_code();
    apply_reset();
    hold(16'hA040, 10);
    hold(16'hAB40, 10);
    checks++;
    if (evt_q.size() != 2 || evk_q[evk_q.size()-1] !== 2'd2 || evt_q[evt_q.size()-1] !== 4'd0)
      $display("FAIL fail_code_event: got %0d events, last kind %0d want 2 events, last kind 2",
               evt_q.size(), evk_q.size() ? evk_q[evk_q.size()-1] : 2'd0);
    else passed++;
    checks++;
    if (fail_mask !== 4'b0001 || fail !== 1'b1)
      $display("FAIL fail_code_flags: got fail_mask=%h fail=%b want 1 1", fail_mask, fail);
    else passed++;
    hold(16'hAB41, 10);
    checks++;
    if (evt_q.size() != 2 || done !== 1'b0)
      $display("FAIL frozen_after_fail: got %0d events done=%b want 2 events done=0",
               evt_q.size(), done);
    else passed++;
  endtask

  task automatic test_protocol_error();
    apply_reset();
    hold(16'hAB21, 10);
    checks++;
    if (evt_q.size() != 1 || evt_q[0] !== 4'd1 || evk_q[0] !== 2'd3)
      $display("FAIL perr_event: got %0d events (first test %0d kind %0d) want 1 event test 1 kind 3",
               evt_q.size(), evt_q.size() ? evt_q[0] : 4'd0, evk_q.size() ? evk_q[0] : 2'd0);
    else passed++;
    checks++;
    if (fail_mask !== 4'b0010 || fail !== 1'b1)
      $display("FAIL perr_flags: got fail_mask=%h fail=%b want 2 1", fail_mask, fail);
    else passed++;
  endtask

  task automatic test_repeat_codes();
    apply_reset();
    hold(16'hA040, 10);
    hold(16'h0000, 10);
    hold(16'hA040, 10);
    checks++;
    if (evt_q.size() != 1 || fail !== 1'b0)
      $display("FAIL repeated_start: got %0d events fail=%b want 1 event fail=0", evt_q.size(), fail);
    else passed++;
    hold(16'hAB41, 10);
    hold(16'hA040, 10);
    checks++;
    if (evt_q.size() != 3 || evk_q[evk_q.size()-1] !== 2'd3)
      $display("FAIL code_after_pass: got %0d events, last kind %0d want 3 events, last kind 3",
               evt_q.size(), evk_q.size() ? evk_q[evk_q.size()-1] : 2'd0);
    else passed++;
    checks++;
    if ({pass_mask, fail_mask, fail} !== 9'b0001_0001_1)
      $display("FAIL code_after_pass_flags: got pass=%h fail_mask=%h fail=%b want 1 1 1",
               pass_mask, fail_mask, fail);
    else passed++;
  endtask

  task automatic test_glitch_latency();
    int lat = 0;
    int n_ev = 0;
    apply_reset();
    hold(16'h0000, 10);
    hold(16'hA040, 3);
    hold(16'h0000, 10);
    checks++;
    if (evt_q.size() != 0) $display("FAIL glitch_rejected: got %0d events want 0", evt_q.size());
    else passed++;
    status = 16'hA040;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clock);
      #1;
      if (event_valid) begin
        n_ev++;
        if (lat == 0) lat = k;
      end
      if (k == 4) status = 16'h0000;
    end
    checks++;
    if (lat != 6) $display("FAIL accept_latency: got %0d cycles want 6", lat);
    else passed++;
    checks++;
    if (n_ev != 1) $display("FAIL accept_once: got %0d pulses want 1", n_ev);
    else passed++;
  endtask

  task automatic test_watchdog();
    int n = 0;
    int found = 0;
    apply_reset();
    status = 16'hA040;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(posedge clock);
      #1;
      if (event_valid) found = 1;
    end
    checks++;
    if (found == 0) $display("FAIL wd_start_event: got no event want one within 20 cycles");
    else passed++;
    while (timeout !== 1'b1 && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    checks++;
    if (n != 100) $display("FAIL wd_expiry_cycles: got %0d want 100", n);
    else passed++;
    checks++;
    if (fail !== 1'b1 || done !== 1'b0)
      $display("FAIL wd_fail_flag: got fail=%b done=%b want 1 0", fail, done);
    else passed++;
    #2;
    resetb = 1'b0;
    #1;
    checks++;
    if ({event_valid, pass_mask, fail_mask, done, fail, timeout} !== 12'h000)
      $display("FAIL midtest_reset: got %h want 000",
               {event_valid, pass_mask, fail_mask, done, fail, timeout});
    else passed++;
    @(negedge clock);
    resetb = 1'b1;
  endtask

  task automatic test_start_order();
    apply_reset();
    hold(16'hA020, 10);
`ifdef MON_STRICT_ORDER_EN
    checks++;
    if (evt_q.size() != 1 || evt_q[0] !== 4'd1 || evk_q[0] !== 2'd3)
      $display("FAIL order_event: got %0d events want 1 event test 1 kind 3", evt_q.size());
    else passed++;
    checks++;
    if (fail !== 1'b1 || fail_mask !== 4'b0010)
      $display("FAIL order_flags: got fail=%b fail_mask=%h want 1 2", fail, fail_mask);
    else passed++;
`else
    checks++;
    if (evt_q.size() != 1 || evt_q[0] !== 4'd1 || evk_q[0] !== 2'd0)
      $display("FAIL order_event: got %0d events want 1 event test 1 kind 0", evt_q.size());
    else passed++;
    checks++;
    if (fail !== 1'b0 || fail_mask !== 4'b0000)
      $display("FAIL order_flags: got fail=%b fail_mask=%h want 0 0", fail, fail_mask);
    else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_all_pass();
    test_fail_code();
    test_protocol_error();
    test_repeat_codes();
    test_glitch_latency();
    test_watchdog();
    test_start_order();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
